time_bus_ctrl: RTL and testbench
================================

Name: time_bus_ctrl

Overview:
Bus master at the far end of the shared 6-bit time databus. It periodically reads the hour, minute and second counters by strobing their enable lines and capturing the databus. It writes user-set values into a selected counter by driving write data and that counter's load line. It presents an atomic snapshot (hour/min/sec) to the display path.

Parameters:
SETTLE, 1, cycles an enable line is held before the databus is sampled (range 1-15).
LD_HOLD, 2, cycles a load line and wr_data are held (range 1-255; must cover at least one counter clock edge).

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
tick  in  1  one-cycle scan request
databus  in  6  shared read bus (zero when no enable is active)
set_req  in  1  write request; level, held until set_ack
set_sel  in  2  write target: 0 = hour, 1 = min, 2 = sec, 3 = invalid
set_val  in  6  value to write
hour_en, min_en, sec_en  out  1 each  read enables, one-hot or all zero
hour_ld, min_ld, sec_ld  out  1 each  load strobes, one-hot or all zero
wr_data  out  6  write data to the counters
set_ack  out  1  one-cycle pulse when a write request completes
set_err  out  1  valid with set_ack; 1 = request rejected, nothing written
disp_hour, disp_min, disp_sec  out  6 each  last complete snapshot
snap_valid  out  1  one-cycle pulse when the snapshot updates
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async assert, sync release): FSM enters IDLE. All en/ld outputs = 0, wr_data = 0, disp_* = 0, set_ack = set_err = snap_valid = 0, pending tick flag cleared. Reset mid-scan or mid-write aborts the operation; no partial snapshot is committed.
- FSM states: IDLE, RD_H, RD_M, RD_S, COMMIT, WR, ACK.
- Pending flag:
  - tick sets tick_pend in any state.
  - Multiple ticks while busy collapse to one.
  - tick_pend clears on entry to RD_H.
- IDLE priority:
  - set_req = 1 and no ack issued this request → validation.
  - Otherwise tick_pend → RD_H.
  - Otherwise stay in IDLE.
  - A write never interrupts a scan in progress; a scan never interrupts a write.
- Read states:
  - RD_x asserts only x_en for SETTLE cycles.
  - On the last cycle, databus is captured into a shadow register, then FSM advances RD_H → RD_M → RD_S → COMMIT.
  - Read latency from tick (sampled in IDLE) to snap_valid = 3*SETTLE+1 cycles.
- COMMIT:
  - All three shadows copy into disp_* in the same cycle; snap_valid pulses.
  - Return to IDLE.
- Validation (combinational in IDLE):
  - Reject if set_sel = 3, or set_sel = 0 and set_val > 23, or set_sel ≠ 0 and set_val > 59.
  - Reject → ACK with set_err = 1; no ld asserted.
  - Accept → WR.
- WR:
  - wr_data = set_val, captured on entry to WR.
  - Selected x_ld high for LD_HOLD cycles; all en = 0 throughout.
  - Then ACK.
  - wr_data returns to 0 on exit from WR.
- ACK:
  - set_ack = 1 for one cycle, with set_err.
  - Return to IDLE.
  - A new write is not accepted until set_req has been seen low for at least one cycle (edge-qualified; no double write on a held request).
- Invariant: at most one of the six en/ld outputs is high in any cycle.
- disp_* change only in COMMIT.

Test Plan:
1. Reset, then tick with databus modelled as en-gated 13/45/07 → RD_H/RD_M/RD_S each 1 cycle (SETTLE=1). snap_valid at cycle 4, disp = 13/45/07.
2. set_req, sel=1, val=30 → min_ld high exactly 2 cycles with wr_data=30. set_ack=1, set_err=0 one cycle later. No en during the write.
3. Invalid requests, each → set_ack with set_err=1 and zero ld pulses: sel=0/val=24, sel=2/val=60, sel=3/val=0.
4. tick and set_req in the same IDLE cycle → write completes first, then scan. Three extra ticks during the write yield exactly one scan.
5. rst_n pulsed low during RD_M → all outputs 0 immediately, disp stays 0, no snap_valid. The next tick performs a full clean scan.
6. set_req held high for 10 cycles after ack → exactly one write. Drop, re-raise → second write occurs. One-hot check on en/ld across a random 2000-cycle run.

Source files
------------

// File: rtl/time_bus_ctrl.sv
// Bus master for the shared 6-bit time databus. It scans hour/min/sec into an
// atomic display snapshot and writes validated user values through load strobes.
module time_bus_ctrl #(
    parameter int SETTLE  = 1,
    parameter int LD_HOLD = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic [5:0] databus,
    input  logic       set_req,
    input  logic [1:0] set_sel,
    input  logic [5:0] set_val,
    output logic       hour_en,
    output logic       min_en,
    output logic       sec_en,
    output logic       hour_ld,
    output logic       min_ld,
    output logic       sec_ld,
    output logic [5:0] wr_data,
    output logic       set_ack,
    output logic       set_err,
    output logic [5:0] disp_hour,
    output logic [5:0] disp_min,
    output logic [5:0] disp_sec,
    output logic       snap_valid,
    output logic       busy,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_H   = 3'd1,
        S_RD_M   = 3'd2,
        S_RD_S   = 3'd3,
        S_COMMIT = 3'd4,
        S_WR     = 3'd5,
        S_ACK    = 3'd6
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [7:0] LD_LAST     = 8'(LD_HOLD - 1);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_cnt;
    logic       r_tick_pend;
    logic       r_acked;
    logic [1:0] r_sel;
    logic       r_err;
    logic [5:0] r_wr_data;
    logic [5:0] r_sh_h;
    logic [5:0] r_sh_m;
    logic [5:0] r_disp_h;
    logic [5:0] r_disp_m;
    logic [5:0] r_disp_s;

    logic       w_last;
    logic       w_req_new;
    logic       w_req_bad;
    logic       w_go_scan;

    // Write handshake: set_req is a level held by the requester until set_ack
    // pulses for one cycle; a request only counts again after set_req drops.
    always_comb begin
        w_req_new = set_req && !r_acked;
        w_req_bad = (set_sel == 2'd3)
                 || ((set_sel == 2'd0) && (set_val > 6'd23))
                 || ((set_sel != 2'd0) && (set_val > 6'd59));
        w_go_scan = r_tick_pend || tick;
        case (r_state)
            S_RD_H, S_RD_M, S_RD_S: w_last = (r_cnt == SETTLE_LAST);
            S_WR:                   w_last = (r_cnt == LD_LAST);
            default:                w_last = 1'b0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req_new) begin
                    w_next = w_req_bad ? S_ACK : S_WR;
                end else if (w_go_scan) begin
                    w_next = S_RD_H;
                end
            end
            S_RD_H:   if (w_last) w_next = S_RD_M;
            S_RD_M:   if (w_last) w_next = S_RD_S;
            S_RD_S:   if (w_last) w_next = S_COMMIT;
            S_COMMIT: w_next = S_IDLE;
            S_WR:     if (w_last) w_next = S_ACK;
            S_ACK:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Strobes decode straight from the state so reset drops them at once.
    always_comb begin
        hour_en    = (r_state == S_RD_H);
        min_en     = (r_state == S_RD_M);
        sec_en     = (r_state == S_RD_S);
        hour_ld    = (r_state == S_WR) && (r_sel == 2'd0);
        min_ld     = (r_state == S_WR) && (r_sel == 2'd1);
        sec_ld     = (r_state == S_WR) && (r_sel == 2'd2);
        set_ack    = (r_state == S_ACK);
        set_err    = (r_state == S_ACK) && r_err;
        snap_valid = (r_state == S_COMMIT);
        busy       = (r_state != S_IDLE);
        wr_data    = r_wr_data;
        disp_hour  = r_disp_h;
        disp_min   = r_disp_m;
        disp_sec   = r_disp_s;
        dbg_state  = r_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_next != r_state) begin
            r_cnt <= '0;
        end else if (r_state inside {S_RD_H, S_RD_M, S_RD_S, S_WR}) begin
            r_cnt <= r_cnt + 8'd1;
        end else begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_pend <= 1'b0;
            r_acked     <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && (w_next == S_RD_H)) begin
                r_tick_pend <= 1'b0;
            end else if (tick) begin
                r_tick_pend <= 1'b1;
            end
            if (!set_req) begin
                r_acked <= 1'b0;
            end else if (r_state == S_ACK) begin
                r_acked <= 1'b1;
            end
        end
    end

    // A rejected request never loads wr_data, so it stays zero through ACK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel     <= 2'd0;
            r_err     <= 1'b0;
            r_wr_data <= '0;
        end else if ((r_state == S_IDLE) && w_req_new) begin
            r_sel <= set_sel;
            r_err <= w_req_bad;
            if (!w_req_bad) begin
                r_wr_data <= set_val;
            end
        end else if ((r_state == S_WR) && w_last) begin
            r_wr_data <= '0;
        end
    end

    // Seconds go straight from the bus into the display on the RD_S->COMMIT
    // edge, so the whole snapshot is visible during the snap_valid cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_h   <= '0;
            r_sh_m   <= '0;
            r_disp_h <= '0;
            r_disp_m <= '0;
            r_disp_s <= '0;
        end else if (w_last) begin
            case (r_state)
                S_RD_H: r_sh_h <= databus;
                S_RD_M: r_sh_m <= databus;
                S_RD_S: begin
                    r_disp_h <= r_sh_h;
                    r_disp_m <= r_sh_m;
                    r_disp_s <= databus;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_time_bus_ctrl.sv
// Self-checking bench for time_bus_ctrl: an operation-level model expands each
// scan/write into its expected per-cycle output trace; directed literals pin it.
module tb_time_bus_ctrl;

    localparam int SETTLE  = 1;
    localparam int LD_HOLD = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       set_req = 1'b0;
    logic [1:0] set_sel = 2'd0;
    logic [5:0] set_val = 6'd0;
    logic [5:0] databus;
    logic       hour_en, min_en, sec_en;
    logic       hour_ld, min_ld, sec_ld;
    logic [5:0] wr_data;
    logic       set_ack, set_err;
    logic [5:0] disp_hour, disp_min, disp_sec;
    logic       snap_valid, busy;
    logic [2:0] dbg_state;

    logic [5:0] bus_h = 6'd13;
    logic [5:0] bus_m = 6'd45;
    logic [5:0] bus_s = 6'd7;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    time_bus_ctrl #(.SETTLE(SETTLE), .LD_HOLD(LD_HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .databus(databus),
        .set_req(set_req), .set_sel(set_sel), .set_val(set_val),
        .hour_en(hour_en), .min_en(min_en), .sec_en(sec_en),
        .hour_ld(hour_ld), .min_ld(min_ld), .sec_ld(sec_ld),
        .wr_data(wr_data), .set_ack(set_ack), .set_err(set_err),
        .disp_hour(disp_hour), .disp_min(disp_min), .disp_sec(disp_sec),
        .snap_valid(snap_valid), .busy(busy), .dbg_state(dbg_state)
    );

    // Counters on a shared bus: each drives its value only while enabled.
    assign databus = (hour_en ? bus_h : 6'd0) | (min_en ? bus_m : 6'd0) | (sec_en ? bus_s : 6'd0);

    always #5 clk = ~clk;

    // ---------------- model ----------------
    logic [33:0] exp_q[$];
    logic        m_pend  = 1'b0;
    logic        m_acked = 1'b0;
    logic [5:0]  m_dh = 6'd0, m_dm = 6'd0, m_ds = 6'd0;
    logic [33:0] exp_w, got_w;

    function automatic logic [33:0] mk(input logic [2:0] en, input logic [2:0] ld,
                                       input logic [5:0] wd, input logic ack, input logic err,
                                       input logic [5:0] dh, input logic [5:0] dm,
                                       input logic [5:0] ds, input logic snap, input logic bsy);
        return {en, ld, wd, ack, err, dh, dm, ds, snap, bsy};
    endfunction

    function automatic void push_scan();
        logic [2:0] en_bit;
        for (int r = 0; r < 3; r++) begin
            en_bit = 3'b100 >> r;
            for (int i = 0; i < SETTLE; i++) exp_q.push_back(mk(en_bit, 3'b000, 6'd0, 1'b0, 1'b0, m_dh, m_dm, m_ds, 1'b0, 1'b1));
        end
        exp_q.push_back(mk(3'b000, 3'b000, 6'd0, 1'b0, 1'b0, bus_h, bus_m, bus_s, 1'b1, 1'b1));
    endfunction

    function automatic void push_write(input logic [1:0] sel, input logic [5:0] val);
        int  limit;
        logic bad;
        limit = (sel == 2'd0) ? 23 : 59;
        bad = (sel == 2'd3) || (int'(val) > limit);
        if (!bad) begin
            for (int i = 0; i < LD_HOLD; i++) exp_q.push_back(mk(3'b000, 3'b100 >> sel, val, 1'b0, 1'b0, m_dh, m_dm, m_ds, 1'b0, 1'b1));
        end
        exp_q.push_back(mk(3'b000, 3'b000, 6'd0, 1'b1, bad, m_dh, m_dm, m_ds, 1'b0, 1'b1));
    endfunction

    always @(negedge clk) begin
        cyc++;
        got_w = mk({hour_en, min_en, sec_en}, {hour_ld, min_ld, sec_ld}, wr_data, set_ack, set_err,
                   disp_hour, disp_min, disp_sec, snap_valid, busy);
        if (!rst_n) begin
            exp_q.delete();
            m_pend = 1'b0;
            m_acked = 1'b0;
            m_dh = 6'd0; m_dm = 6'd0; m_ds = 6'd0;
            exp_w = '0;
        end else if (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            if (exp_w[1]) {m_dh, m_dm, m_ds} = exp_w[19:2];
            if (tick) m_pend = 1'b1;
        end else begin
            exp_w = mk(3'b000, 3'b000, 6'd0, 1'b0, 1'b0, m_dh, m_dm, m_ds, 1'b0, 1'b0);
            if (set_req && !m_acked) begin
                push_write(set_sel, set_val);
                if (tick) m_pend = 1'b1;
            end else if (m_pend || tick) begin
                push_scan();
                m_pend = 1'b0;
            end
        end
        if (rst_n) begin
            if (!set_req) m_acked = 1'b0;
            else if (exp_w[21]) m_acked = 1'b1;
        end
        n_checks++;
        if (got_w !== exp_w) begin
            n_fail++;
            $display("FAIL model_cycle cyc=%0d got=%h exp=%h", cyc, got_w, exp_w);
        end
        n_checks++;
        if ($countones(got_w[33:28]) > 1) begin
            n_fail++;
            $display("FAIL onehot_en_ld cyc=%0d got=%b exp=at most one set", cyc, got_w[33:28]);
        end
    end

    // ---------------- event counters ----------------
    int h_ld_n = 0, m_ld_n = 0, s_ld_n = 0, ack_n = 0, snap_n = 0;
    logic [5:0] last_wd = 6'd0;

    always @(negedge clk) begin
        if (hour_ld) h_ld_n++;
        if (min_ld)  m_ld_n++;
        if (sec_ld)  s_ld_n++;
        if (set_ack) ack_n++;
        if (snap_valid) snap_n++;
        if (hour_ld || min_ld || sec_ld) last_wd = wr_data;
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic measure_scan(output int lat);
        @(posedge clk); #1 tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
        lat = 1;
        while (lat < 40) begin
            @(negedge clk);
            if (snap_valid) break;
            lat++;
        end
    endtask

    task automatic do_write(input logic [1:0] sel, input logic [5:0] val, input int hold_after, output logic err);
        logic got;
        got = 1'b0;
        err = 1'b0;
        @(posedge clk); #1 set_req = 1'b1; set_sel = sel; set_val = val;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (set_ack) begin
                got = 1'b1;
                err = set_err;
            end
        end
        check("ack_seen", int'(got), 1);
        repeat (hold_after) @(posedge clk);
        @(posedge clk); #1 set_req = 1'b0;
    endtask

    task automatic wait_model_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !m_pend) break;
        end
        @(posedge clk); #1;
    endtask

    // ---------------- directed + random stimulus ----------------
    int lat;
    logic err;
    int h0, m0, s0, a0, sn0;
    logic [1:0] bad_sel[3] = '{2'd0, 2'd2, 2'd3};
    logic [5:0] bad_val[3] = '{6'd24, 6'd60, 6'd0};

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_disp_hour", int'(disp_hour), 0);
        check("reset_wr_data", int'(wr_data), 0);

        // 1: first scan, latency and captured values
        measure_scan(lat);
        check("scan_latency", lat, 4);
        check("scan1_hour", int'(disp_hour), 13);
        check("scan1_min", int'(disp_min), 45);
        check("scan1_sec", int'(disp_sec), 7);

        // 2: valid minute write
        h0 = h_ld_n; m0 = m_ld_n; s0 = s_ld_n;
        do_write(2'd1, 6'd30, 0, err);
        check("wr_min_err", int'(err), 0);
        check("wr_min_ld_cycles", m_ld_n - m0, 2);
        check("wr_min_other_ld", (h_ld_n - h0) + (s_ld_n - s0), 0);
        check("wr_min_data", int'(last_wd), 30);

        // 3: rejected writes
        for (int i = 0; i < 3; i++) begin
            h0 = h_ld_n + m_ld_n + s_ld_n;
            do_write(bad_sel[i], bad_val[i], 0, err);
            check("reject_err", int'(err), 1);
            check("reject_no_ld", h_ld_n + m_ld_n + s_ld_n - h0, 0);
        end

        // 4: tick and request together; write first, extra ticks collapse
        sn0 = snap_n;
        @(posedge clk); #1 tick = 1'b1; set_req = 1'b1; set_sel = 2'd2; set_val = 6'd5;
        @(negedge clk);
        check("t4_idle_at_start", int'(busy), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t4_sec_ld_first", int'(sec_ld), 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("t4_ack_before_scan", int'(set_ack && !set_err), 1);
        check("t4_no_snap_yet", snap_n - sn0, 0);
        @(posedge clk); #1 tick = 1'b0; set_req = 1'b0;
        repeat (15) @(posedge clk);
        check("t4_single_scan", snap_n - sn0, 1);

        // 5: reset in the middle of a scan
        #1 bus_h = 6'd21; bus_m = 6'd5; bus_s = 6'd59;
        @(posedge clk); #1 tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        check("t5_busy_in_reset", int'(busy), 0);
        check("t5_min_en_in_reset", int'(min_en), 0);
        check("t5_disp_cleared", int'(disp_hour), 0);
        sn0 = snap_n;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (8) @(posedge clk);
        check("t5_no_snap_after_abort", snap_n - sn0, 0);
        check("t5_disp_stays_zero", int'(disp_min), 0);
        measure_scan(lat);
        check("t5_rescan_latency", lat, 4);
        check("t5_rescan_hour", int'(disp_hour), 21);
        check("t5_rescan_sec", int'(disp_sec), 59);

        // 6: held request writes once; drop and re-raise writes again
        h0 = h_ld_n; a0 = ack_n;
        do_write(2'd0, 6'd12, 10, err);
        check("t6_held_one_write", h_ld_n - h0, 2);
        check("t6_held_one_ack", ack_n - a0, 1);
        do_write(2'd0, 6'd23, 0, err);
        check("t6_second_write", h_ld_n - h0, 4);
        check("t6_second_err", int'(err), 0);

        // random mix; the model and one-hot checks run every cycle
        a0 = cyc;
        while (cyc < a0 + 2000) begin
            case ($urandom_range(0, 9))
                0, 1, 2: begin
                    @(posedge clk); #1 tick = 1'b1;
                    @(posedge clk); #1 tick = 1'b0;
                end
                3, 4, 5: do_write(2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), $urandom_range(0, 3), err);
                6: begin
                    wait_model_idle();
                    bus_h = 6'($urandom_range(0, 63));
                    bus_m = 6'($urandom_range(0, 63));
                    bus_s = 6'($urandom_range(0, 63));
                end
                default: repeat ($urandom_range(1, 5)) @(posedge clk);
            endcase
        end

        repeat (20) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "watchdog");
    end

endmodule
